// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier (MUL / UMULL / SMULL) with register-file write-back.
// Latency: start edge -> WIDTH CALC cycles -> one DONE cycle (result written at the end of cycle WIDTH+1).
// Backpressure: start is only honoured in IDLE; starts while busy are dropped, nothing is queued.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_long,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       wa_lo,
    input  logic [3:0]       wa_hi,
    output logic             busy,
    output logic             done,
    output logic             we_lo,
    output logic [3:0]       wa_lo_q,
    output logic [WIDTH-1:0] wd_lo,
    output logic             we_hi,
    output logic [3:0]       wa_hi_q,
    output logic [WIDTH-1:0] wd_hi
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left once per step
    logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right once per step
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_long;
    logic [3:0]         r_wa_lo;
    logic [3:0]         r_wa_hi;

    logic               w_sgn_mode;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_last;

    // Signed-long operands are reduced to magnitudes; the sign is reapplied after the last step.
    // The magnitude of the most negative value is still representable as WIDTH-bit unsigned.
    assign w_sgn_mode = is_long & is_signed;
    assign w_mag_a    = (w_sgn_mode && a[WIDTH-1]) ? -a : a;
    assign w_mag_b    = (w_sgn_mode && b[WIDTH-1]) ? -b : b;
    assign w_sum      = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == LAST_CNT);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture in IDLE and one shift-add step per CALC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_long   <= 1'b0;
            r_wa_lo  <= '0;
            r_wa_hi  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_sgn_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_long   <= is_long;
                        r_wa_lo  <= wa_lo;
                        r_wa_hi  <= wa_hi;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc    <= (w_last && r_neg) ? -w_sum : w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded purely from registered state so strobes never glitch.
    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        we_lo   = done;
        we_hi   = done & r_long;
        wa_lo_q = r_wa_lo;
        wa_hi_q = r_wa_hi;
        wd_lo   = done ? r_acc[WIDTH-1:0]       : '0;
        wd_hi   = done ? r_acc[2*WIDTH-1:WIDTH] : '0;
    end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed vectors push expected write-backs, a monitor checks them.
// Latency checks are made against the cycle count after each start.
// Starts issued while busy are not pushed, so any extra done pulse is flagged.
module tb_mul_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          is_long = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    wa_lo = '0;
    logic [3:0]    wa_hi = '0;
    logic          busy, done, we_lo, we_hi;
    logic [3:0]    wa_lo_q, wa_hi_q;
    logic [W-1:0]  wd_lo, wd_hi;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         lng;
        logic [3:0]   wlo;
        logic [3:0]   whi;
        string        name;
    } exp_t;

    exp_t sb[$];

    mul_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_long(is_long), .is_signed(is_signed),
        .a(a), .b(b), .wa_lo(wa_lo), .wa_hi(wa_hi),
        .busy(busy), .done(done),
        .we_lo(we_lo), .wa_lo_q(wa_lo_q), .wd_lo(wd_lo),
        .we_hi(we_hi), .wa_hi_q(wa_hi_q), .wd_hi(wd_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write-back must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_we_lo"}, 64'(we_lo), 64'd1);
                    check({e.name, "_we_hi"}, 64'(we_hi), 64'(e.lng));
                    check({e.name, "_wd_lo"}, 64'(wd_lo), 64'(e.lo));
                    check({e.name, "_wa_lo"}, 64'(wa_lo_q), 64'(e.wlo));
                    if (e.lng) begin
                        check({e.name, "_wd_hi"}, 64'(wd_hi), 64'(e.hi));
                        check({e.name, "_wa_hi"}, 64'(wa_hi_q), 64'(e.whi));
                    end
                end
            end else if (we_lo || we_hi) begin
                check("write_without_done", {62'd0, we_hi, we_lo}, 64'd0);
            end
        end
    end

    // Called at a negedge in cycle 0; returns at the negedge of cycle 1.
    task automatic start_op(input string name, input logic lng, input logic sgn,
                            input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [3:0] wl, input logic [3:0] wh,
                            input logic push, input logic [W-1:0] elo, input logic [W-1:0] ehi);
        exp_t e;
        start = 1'b1; is_long = lng; is_signed = sgn; a = ia; b = ib; wa_lo = wl; wa_hi = wh;
        if (push) begin
            e.lo = elo; e.hi = ehi; e.lng = lng; e.wlo = wl; e.whi = wh; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        // Inputs may change freely after the start edge.
        a = $urandom; b = $urandom; wa_lo = 4'($urandom); wa_hi = 4'($urandom);
        is_long = 1'($urandom); is_signed = 1'($urandom);
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        wait_cyc(3);
        check("reset_outputs",
              {busy, done, we_lo, we_hi, wa_lo_q, wa_hi_q, wd_lo, wd_hi[W-1:12]},
              64'd0);
        reset = 1'b0;
        wait_cyc(2);

        // MUL 7*6 with cycle-exact latency checks.
        start_op("mul_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 4'd2, 4'd3, 1'b1, 32'd42, 32'd0);
        check("busy_cycle1", 64'(busy), 64'd1);
        wait_cyc(32);
        check("done_cycle33", 64'(done), 64'd1);
        check("we_hi_mul_cycle33", 64'(we_hi), 64'd0);
        wait_cyc(1);
        check("busy_cycle34", 64'(busy), 64'd0);
        check("done_cycle34", 64'(done), 64'd0);
        wait_cyc(1);

        start_op("umull_max", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 4'd5, 1'b1,
                 32'h00000001, 32'hFFFFFFFE);
        wait_idle();
        start_op("smull_m3x5", 1'b1, 1'b1, 32'hFFFFFFFD, 32'd5, 4'd6, 4'd7, 1'b1,
                 32'hFFFFFFF1, 32'hFFFFFFFF);
        wait_idle();
        start_op("smull_minxmin", 1'b1, 1'b1, 32'h80000000, 32'h80000000, 4'd8, 4'd9, 1'b1,
                 32'h00000000, 32'h40000000);
        wait_idle();
        start_op("smull_7xm2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 4'd10, 4'd11, 1'b1,
                 32'hFFFFFFF2, 32'hFFFFFFFF);
        wait_idle();
        start_op("umull_shift", 1'b1, 1'b0, 32'h12345678, 32'h10, 4'd12, 4'd12, 1'b1,
                 32'h23456780, 32'h00000001);
        wait_idle();
        // is_signed must be ignored for MUL; low word is the same either way.
        start_op("mul_signed_flag", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 4'd13, 4'd14, 1'b1,
                 32'hFFFFFFF1, 32'd0);
        wait_idle();

        // UMULL 3*4 with a stray start in cycle 10.
        start_op("umull_3x4", 1'b1, 1'b0, 32'd3, 32'd4, 4'd1, 4'd2, 1'b1, 32'd12, 32'd0);
        wait_cyc(9);
        start = 1'b1; a = 32'd9; b = 32'd9; is_long = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        check("busy_after_stray_start", 64'(busy), 64'd1);
        wait_idle();

        // Start in the DONE cycle is ignored; start in the following cycle is accepted.
        start_op("mul_5x5", 1'b0, 1'b0, 32'd5, 32'd5, 4'd3, 4'd0, 1'b1, 32'd25, 32'd0);
        wait_cyc(32);
        check("done_before_ignored_start", 64'(done), 64'd1);
        start = 1'b1; a = 32'd100; b = 32'd100; is_long = 1'b0;
        wait_cyc(1);
        check("start_in_done_ignored", 64'(busy), 64'd0);
        start_op("mul_8x9", 1'b0, 1'b0, 32'd8, 32'd9, 4'd15, 4'd0, 1'b1, 32'd72, 32'd0);
        check("start_after_done_accepted", 64'(busy), 64'd1);
        wait_idle();

        // Reset in cycle 15 aborts with no write-back.
        start_op("aborted", 1'b1, 1'b0, 32'd11, 32'd13, 4'd5, 4'd6, 1'b0, 32'd0, 32'd0);
        wait_cyc(14);
        reset = 1'b1;
        #1;
        check("busy_async_reset", 64'(busy), 64'd0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(40);
        check("idle_after_abort", 64'(busy), 64'd0);
        start_op("mul_2x3", 1'b0, 1'b0, 32'd2, 32'd3, 4'd7, 4'd8, 1'b1, 32'd6, 32'd0);
        wait_idle();

        wait_cyc(2);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
